// File: rtl/ccl_pkg.sv
// rtl/ccl_pkg.sv - shared types and defaults for the connected-component labeling datapath
package ccl_pkg;

    localparam int COLS_DEF = 320;
    localparam int ROWS_DEF = 240;
    localparam int LW_DEF   = 16;

    typedef logic [LW_DEF-1:0] label_t;
    localparam label_t BG_LABEL = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // counter width that stays at least one bit for degenerate sizes
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccl_scan_sequencer_if.sv
// rtl/ccl_scan_sequencer_if.sv - control, pixel, label and merge channels of the scan sequencer
interface ccl_scan_sequencer_if #(
    parameter int LW = 16
);
    logic          start;
    logic          busy;
    logic          done;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_fg;
    logic          lbl_valid;
    logic          lbl_ready;
    logic [LW-1:0] lbl_data;
    logic          mrg_valid;
    logic          mrg_ready;
    logic [LW-1:0] mrg_a;
    logic [LW-1:0] mrg_b;
    logic [LW-1:0] label_count;
    logic          overflow;

    modport master (
        output start, pix_valid, pix_fg, lbl_ready, mrg_ready,
        input  busy, done, pix_ready, lbl_valid, lbl_data,
               mrg_valid, mrg_a, mrg_b, label_count, overflow
    );

    modport slave (
        input  start, pix_valid, pix_fg, lbl_ready, mrg_ready,
        output busy, done, pix_ready, lbl_valid, lbl_data,
               mrg_valid, mrg_a, mrg_b, label_count, overflow
    );
endinterface

// File: rtl/ccl_line_buf.sv
// rtl/ccl_line_buf.sv - previous-row label store, one write port and one registered read port
module ccl_line_buf #(
    parameter int COLS = 320,
    parameter int LW   = 16,
    parameter int AW   = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [LW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [LW-1:0] rdata
);
    logic [LW-1:0] mem [COLS];

    // read data holds while re is low so a stalled pixel keeps its neighbour
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ccl_scan_sequencer.sv
// rtl/ccl_scan_sequencer.sv - raster-scan label sequencer; merge channel enabled by CCL_MERGE_EN
module ccl_scan_sequencer
    import ccl_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    ccl_scan_sequencer_if.slave s
);
    localparam int CW = cnt_w(COLS);
    localparam int RW = cnt_w(ROWS);
    localparam logic [LW-1:0] MAXL = '1;
    localparam logic [LW-1:0] BG   = LW'(BG_LABEL);

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [LW-1:0] c1, w2, w3, rd_data;
    logic [LW-1:0] lbl_q, cnt_q;
    logic          busy_q, done_q, lbl_v_q, ovf_q, mrg_v;
    logic          accept, alloc, first_row, first_col, last_col, last_row;
    logic [LW-1:0] n1, n2, n3, n4, lbl_n;
    logic [CW-1:0] rd_addr;

    assign first_row = (row == '0);
    assign first_col = (col == '0);
    assign last_col  = (col == CW'(COLS - 1));
    assign last_row  = (row == RW'(ROWS - 1));

    assign n1 = first_col ? BG : c1;
    assign n2 = (first_row || first_col) ? BG : w2;
    assign n3 = first_row ? BG : w3;
    assign n4 = (first_row || last_col) ? BG : rd_data;

    assign s.pix_ready = (state == S_RUN) && (!lbl_v_q || s.lbl_ready) && !mrg_v;
    assign accept      = s.pix_valid && s.pix_ready;

    // reads run two columns ahead so c4 sits on the RAM output when its pixel is accepted
    assign rd_addr = (state != S_RUN)            ? '0 :
                     (col >= CW'(COLS - 2))      ? col - CW'(COLS - 2) :
                                                   col + CW'(2);

    ccl_line_buf #(.COLS(COLS), .LW(LW), .AW(CW)) u_line_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (col),
        .wdata (lbl_n),
        .re    (accept || (state == S_PRIME)),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        lbl_n = BG;
        alloc = 1'b0;
        if (!s.pix_fg)       lbl_n = BG;
        else if (n3 != BG)   lbl_n = n3;
        else if (n1 != BG)   lbl_n = n1;
        else if (n2 != BG)   lbl_n = n2;
        else if (n4 != BG)   lbl_n = n4;
        else begin
            alloc = 1'b1;
            lbl_n = (cnt_q == MAXL) ? MAXL : cnt_q + 1'b1;
        end
    end

`ifdef CCL_MERGE_EN
    logic          mrg_hit;
    logic [LW-1:0] mrg_b_n, mrg_a_q, mrg_b_q;

    assign mrg_b_n = (n1 != BG) ? n1 : n2;
    assign mrg_hit = s.pix_fg && (n3 == BG) && (n4 != BG) && (mrg_b_n != BG) && (n4 != mrg_b_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mrg_v   <= 1'b0;
            mrg_a_q <= '0;
            mrg_b_q <= '0;
        end else if (accept && mrg_hit) begin
            mrg_v   <= 1'b1;
            mrg_a_q <= n4;
            mrg_b_q <= mrg_b_n;
        end else if (s.mrg_ready) begin
            mrg_v   <= 1'b0;
        end
    end

    assign s.mrg_valid = mrg_v;
    assign s.mrg_a     = mrg_a_q;
    assign s.mrg_b     = mrg_b_q;
`else
    logic unused_mrg_ready;
    assign unused_mrg_ready = s.mrg_ready;
    assign mrg_v       = 1'b0;
    assign s.mrg_valid = 1'b0;
    assign s.mrg_a     = '0;
    assign s.mrg_b     = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            col     <= '0;
            row     <= '0;
            c1      <= '0;
            w2      <= '0;
            w3      <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lbl_v_q <= 1'b0;
            lbl_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                lbl_v_q <= 1'b1;
                lbl_q   <= lbl_n;
                c1      <= lbl_n;
                w2      <= w3;
                w3      <= rd_data;
                if (alloc) begin
                    if (cnt_q == MAXL) ovf_q <= 1'b1;
                    else               cnt_q <= cnt_q + 1'b1;
                end
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (s.lbl_ready) begin
                lbl_v_q <= 1'b0;
            end

            case (state)
                S_IDLE: if (s.start) begin
                    state  <= S_PRIME;
                    busy_q <= 1'b1;
                    col    <= '0;
                    row    <= '0;
                    cnt_q  <= '0;
                    ovf_q  <= 1'b0;
                end
                S_PRIME: state <= S_RUN;
                S_RUN:   if (accept && last_col && last_row) state <= S_DRAIN;
                S_DRAIN: if (!lbl_v_q && !mrg_v) begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign s.busy        = busy_q;
    assign s.done        = done_q;
    assign s.lbl_valid   = lbl_v_q;
    assign s.lbl_data    = lbl_q;
    assign s.label_count = cnt_q;
    assign s.overflow    = ovf_q;
endmodule

// File: tb/tb_ccl_scan_sequencer.sv
// tb/tb_ccl_scan_sequencer.sv - scoreboard bench for the scan sequencer on 4x3 and 7x1 frames
module tb_ccl_scan_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail  = 0;
    int qa[$];
    int qb[$];
    logic [31:0] qm[$];
    int done_a = 0;
    bit hold_v = 1'b0;
    logic [15:0] hold_d = '0;

    always #5 clk = ~clk;

    ccl_scan_sequencer_if #(.LW(16)) ifa ();
    ccl_scan_sequencer_if #(.LW(2))  ifb ();

    ccl_scan_sequencer #(.COLS(4), .ROWS(3), .LW(16)) dut (
        .clk (clk),
        .rst (rst),
        .s   (ifa.slave)
    );

    ccl_scan_sequencer #(.COLS(7), .ROWS(1), .LW(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .s   (ifb.slave)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("lbl_hold", ifa.lbl_data, hold_d);
            hold_v = ifa.lbl_valid && !ifa.lbl_ready;
            hold_d = ifa.lbl_data;
            if (ifa.lbl_valid && ifa.lbl_ready) begin
                if (qa.size() == 0) chk("lbl_unexpected", qa.size(), 1);
                else                chk("lbl_data", ifa.lbl_data, qa.pop_front());
            end
            if (ifa.mrg_valid && ifa.mrg_ready) begin
                if (qm.size() == 0) chk("merge_unexpected", qm.size(), 1);
                else                chk("merge_pair", {ifa.mrg_a, ifa.mrg_b}, qm.pop_front());
            end
            if (ifa.mrg_valid) chk("ready_low_on_merge", ifa.pix_ready, 0);
            if (ifa.done) done_a++;
            if (ifb.lbl_valid && ifb.lbl_ready) begin
                if (qb.size() == 0) chk("b_lbl_unexpected", qb.size(), 1);
                else                chk("b_ovf_label", {ifb.overflow, ifb.lbl_data}, qb.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [47:0] e, input bit with_merge);
        for (int k = 0; k < 12; k++) qa.push_back(int'(e[4*k +: 4]));
`ifdef CCL_MERGE_EN
        if (with_merge) qm.push_back({16'd2, 16'd1});
`else
        if (with_merge) qm.delete();
`endif
    endtask

    task automatic start_a();
        ifa.start = 1'b1;
        @(posedge clk); #1 ifa.start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", ifa.busy, 1);
        chk("ready_low_in_prime", ifa.pix_ready, 0);
        @(negedge clk);
        chk("ready_in_run", ifa.pix_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic drive_a(input logic [11:0] pat, input int stall_at, input int n);
        bit acc;
        int w;
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                ifa.lbl_ready = 1'b0;
                fork
                    begin
                        repeat (5) begin
                            @(negedge clk);
                            chk("ready_low_stall", ifa.pix_ready, 0);
                        end
                        @(posedge clk); #1 ifa.lbl_ready = 1'b1;
                    end
                join_none
            end
            ifa.pix_valid = 1'b1;
            ifa.pix_fg    = pat[k];
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 200) begin
                @(negedge clk);
                acc = ifa.pix_ready;
                @(posedge clk); #1;
                w++;
            end
            if (!acc) chk("pix_accept_timeout", w, 0);
        end
        ifa.pix_valid = 1'b0;
    endtask

    task automatic finish_a(input int exp_cnt, input bit start_on_done);
        int w = 0;
        while (!ifa.done && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!ifa.done) begin
            chk("done_timeout", w, 0);
        end else if (start_on_done) begin
            ifa.start = 1'b1;
            @(posedge clk); #1 ifa.start = 1'b0;
            @(negedge clk);
            chk("start_on_done_ignored", ifa.busy, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_a, 1);
        chk("busy_after_done", ifa.busy, 0);
        chk("label_count", ifa.label_count, exp_cnt);
        chk("labels_left", qa.size(), 0);
        chk("merges_left", qm.size(), 0);
        done_a = 0;
    endtask

    initial begin
        bit acc;
        int w;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        int w;
        ifa.start = 1'b0; ifa.pix_valid = 1'b0; ifa.pix_fg = 1'b0;
        ifa.lbl_ready = 1'b1; ifa.mrg_ready = 1'b1;
        ifb.start = 1'b0; ifb.pix_valid = 1'b0; ifb.pix_fg = 1'b0;
        ifb.lbl_ready = 1'b1; ifb.mrg_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_pix_ready", ifa.pix_ready, 0);
        chk("rst_lbl_valid", ifa.lbl_valid, 0);
        chk("rst_mrg_valid", ifa.mrg_valid, 0);
        chk("rst_overflow", ifa.overflow, 0);
        chk("rst_lbl_data", ifa.lbl_data, 0);
        chk("rst_mrg_ab", {ifa.mrg_a, ifa.mrg_b}, 0);
        chk("rst_label_count", ifa.label_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // all background, start issued on the done pulse
        push_exp(48'h0, 1'b0);
        start_a();
        drive_a(12'h000, -1, 12);
        finish_a(0, 1'b1);

        // single foreground pixel at (0,0)
        push_exp(48'h1, 1'b0);
        start_a();
        drive_a(12'h001, -1, 12);
        finish_a(1, 1'b0);

        // rows 1001 / 1111 / 0000: one merge (2,1) at (1,2)
        push_exp(48'h0000_2111_2001, 1'b1);
        start_a();
        drive_a(12'h0F9, -1, 12);
        finish_a(2, 1'b0);

        // same frame with label back-pressure and a slow merge consumer
        push_exp(48'h0000_2111_2001, 1'b1);
        ifa.mrg_ready = 1'b0;
        fork
            begin
                int n = 0;
                while (!ifa.mrg_valid && n < 200) begin
                    @(posedge clk); #1;
                    n++;
                end
                repeat (3) @(posedge clk);
                #1 ifa.mrg_ready = 1'b1;
            end
        join_none
        start_a();
        drive_a(12'h0F9, 5, 12);
        finish_a(2, 1'b0);
        ifa.mrg_ready = 1'b1;

        // reset while pixel (1,1) is presented, then relabel the whole frame
        push_exp(48'h0000_2111_2001, 1'b0);
        start_a();
        drive_a(12'h0F9, -1, 5);
        ifa.pix_valid = 1'b1;
        ifa.pix_fg    = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_lbl_valid", ifa.lbl_valid, 0);
        chk("midrst_busy", ifa.busy, 0);
        chk("midrst_pix_ready", ifa.pix_ready, 0);
        chk("midrst_lbl_data", ifa.lbl_data, 0);
        chk("midrst_label_count", ifa.label_count, 0);
        ifa.pix_valid = 1'b0;
        qa.delete();
        qm.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        push_exp(48'h0000_2111_2001, 1'b1);
        start_a();
        drive_a(12'h0F9, -1, 12);
        finish_a(2, 1'b0);

        // LW=2, 1010101: fourth component saturates at 3 and sets overflow
        qb.push_back(1); qb.push_back(0); qb.push_back(2); qb.push_back(0);
        qb.push_back(3); qb.push_back(0); qb.push_back(4 + 3);
        ifb.start = 1'b1;
        @(posedge clk); #1 ifb.start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            ifb.pix_valid = 1'b1;
            ifb.pix_fg    = (k % 2 == 0);
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 200) begin
                @(negedge clk);
                acc = ifb.pix_ready;
                @(posedge clk); #1;
                w++;
            end
            if (!acc) chk("b_accept_timeout", w, 0);
        end
        ifb.pix_valid = 1'b0;
        w = 0;
        while (!ifb.done && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!ifb.done) chk("b_done_timeout", w, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("b_label_count", ifb.label_count, 3);
        chk("b_overflow", ifb.overflow, 1);
        chk("b_labels_left", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
